// File: rtl/return_addr_stack.sv
// return_addr_stack: circular return-address stack with saturating count; RAS_RECOVER_EN adds checkpoint/restore ports.
module return_addr_stack #(
    parameter int DEPTH = 8,
    parameter int AW    = 32,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [AW-1:0] push_addr_i,
    input  logic          flush_i,
`ifdef RAS_RECOVER_EN
    output logic [PW-1:0] ckpt_ptr_o,
    output logic [PW:0]   ckpt_cnt_o,
    input  logic          restore_i,
    input  logic [PW-1:0] restore_ptr_i,
    input  logic [PW:0]   restore_cnt_i,
`endif
    output logic [AW-1:0] top_addr_o,
    output logic          top_valid_o
);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    logic [AW-1:0] mem_q [DEPTH];
    logic [PW-1:0] ptr_q, ptr_d, wa;
    logic [PW:0]   cnt_q, cnt_d;
    logic          we, empty;

    assign empty       = cnt_q == '0;
    assign top_addr_o  = mem_q[ptr_q];
    assign top_valid_o = !empty;
`ifdef RAS_RECOVER_EN
    assign ckpt_ptr_o  = ptr_q;
    assign ckpt_cnt_o  = cnt_q;
`endif

    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        we    = 1'b0;
        wa    = ptr_q + 1'b1;
`ifdef RAS_RECOVER_EN
        if (restore_i) begin
            ptr_d = restore_ptr_i;
            cnt_d = restore_cnt_i > FULL ? FULL : restore_cnt_i;
        end else
`endif
        if (flush_i) begin
            ptr_d = '0;
            cnt_d = '0;
        end else if (push_i && pop_i && !empty) begin
            // call-and-return in one instruction replaces the top in place
            we = 1'b1;
            wa = ptr_q;
        end else if (push_i) begin
            we    = 1'b1;
            ptr_d = ptr_q + 1'b1;
            cnt_d = cnt_q == FULL ? FULL : cnt_q + 1'b1;
        end else if (pop_i && !empty) begin
            ptr_d = ptr_q - 1'b1;
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            if (we) mem_q[wa] <= push_addr_i;
        end
    end
endmodule

// File: tb/tb_return_addr_stack.sv
// tb_return_addr_stack: directed vector table, corner sequences and queue-model random test for return_addr_stack.
module tb_return_addr_stack;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        push = 1'b0, pop = 1'b0, flush = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] top;
    logic        valid;
`ifdef RAS_RECOVER_EN
    logic [2:0]  ckpt_ptr, rptr = '0, snap_ptr;
    logic [3:0]  ckpt_cnt, rcnt = '0, snap_cnt;
    logic        restore = 1'b0;
`endif
    int checks = 0, failures = 0;

    typedef struct {
        logic        pu, po, fl;
        logic [31:0] a;
        logic        chk_top;
        logic [31:0] top;
        logic        valid;
    } vec_t;
    vec_t vec[$];
    logic [31:0] q[$];

    return_addr_stack #(.DEPTH(8), .AW(32)) dut (
        .clk(clk), .rst_n(rst_n), .push_i(push), .pop_i(pop), .push_addr_i(addr), .flush_i(flush),
`ifdef RAS_RECOVER_EN
        .ckpt_ptr_o(ckpt_ptr), .ckpt_cnt_o(ckpt_cnt), .restore_i(restore),
        .restore_ptr_i(rptr), .restore_cnt_i(rcnt),
`endif
        .top_addr_o(top), .top_valid_o(valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic pu, input logic po, input logic fl, input logic [31:0] a);
        push = pu; pop = po; flush = fl; addr = a;
        @(posedge clk); #1;
        push = 1'b0; pop = 1'b0; flush = 1'b0;
    endtask

    task automatic add(input logic pu, input logic po, input logic fl, input logic [31:0] a,
                       input logic ct, input logic [31:0] t, input logic v);
        vec.push_back('{pu, po, fl, a, ct, t, v});
    endtask

    task automatic model(input logic pu, input logic po, input logic fl, input logic [31:0] a);
        if (fl) q.delete();
        else if (pu && po && q.size() != 0) q[q.size()-1] = a;
        else if (pu) begin
            q.push_back(a);
            if (q.size() > 8) void'(q.pop_front());
        end else if (po && q.size() != 0) void'(q.pop_back());
    endtask

    initial begin
        #2;
        check("reset_top", top, 32'h0);
        check("reset_valid", {31'b0, valid}, 32'h0);
        #5 rst_n = 1'b1;
        @(posedge clk); #1;

        add(1,0,0,32'h100, 1,32'h100,1);
        add(1,0,0,32'h200, 1,32'h200,1);
        add(0,1,0,0,       1,32'h100,1);
        add(0,1,0,0,       1,32'h0,0);
        for (int k = 1; k <= 9; k++) add(1,0,0,32'(k*16), 1,32'(k*16),1);
        for (int k = 1; k <= 7; k++) add(0,1,0,0, 1,32'(144-k*16),1);
        add(0,1,0,0,       0,0,0);
        add(0,1,0,0,       0,0,0);
        add(1,1,0,32'h44,  1,32'h44,1);
        add(0,1,0,0,       0,0,0);
        add(1,0,0,32'h100, 1,32'h100,1);
        add(1,0,0,32'h200, 1,32'h200,1);
        add(1,1,0,32'h300, 1,32'h300,1);
        add(0,1,0,0,       1,32'h100,1);
        add(0,1,0,0,       0,0,0);
        add(1,0,0,32'h1,   1,32'h1,1);
        add(1,0,0,32'h2,   1,32'h2,1);
        add(1,0,0,32'h3,   1,32'h3,1);
        add(1,0,1,32'h4,   0,0,0);
        add(0,1,0,0,       0,0,0);
        add(1,0,0,32'h5,   1,32'h5,1);
        add(0,1,0,0,       0,0,0);
        foreach (vec[i]) begin
            step(vec[i].pu, vec[i].po, vec[i].fl, vec[i].a);
            check($sformatf("vec%0d_valid", i), {31'b0, valid}, {31'b0, vec[i].valid});
            if (vec[i].chk_top) check($sformatf("vec%0d_top", i), top, vec[i].top);
        end

        step(1,0,0,32'hA0);
        step(1,0,0,32'hB0);
        push = 1'b1; addr = 32'hC0;
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_top", top, 32'h0);
        check("async_rst_valid", {31'b0, valid}, 32'h0);
        @(posedge clk); #1;
        check("rst_hold_valid", {31'b0, valid}, 32'h0);
        rst_n = 1'b1;
        step(1,0,0,32'hD0);
        check("post_rst_top", top, 32'hD0);
        step(0,1,0,0);
        check("post_rst_empty", {31'b0, valid}, 32'h0);

`ifdef RAS_RECOVER_EN
        step(1,0,0,32'hA);
        step(1,0,0,32'hB);
        snap_ptr = ckpt_ptr; snap_cnt = ckpt_cnt;
        check("ckpt_cnt", {28'b0, snap_cnt}, 32'd2);
        step(1,0,0,32'hC);
        step(0,1,0,0);
        step(0,1,0,0);
        check("pre_restore_top", top, 32'hA);
        restore = 1'b1; rptr = snap_ptr; rcnt = snap_cnt;
        step(0,1,0,0);
        restore = 1'b0;
        check("restore_top", top, 32'hB);
        check("restore_cnt", {28'b0, ckpt_cnt}, 32'd2);
        step(0,1,0,0);
        restore = 1'b1;
        step(1,0,1,32'hE);
        restore = 1'b0;
        check("restore_vs_flush_top", top, 32'hB);
        check("restore_vs_flush_cnt", {28'b0, ckpt_cnt}, 32'd2);
        restore = 1'b1; rcnt = 4'd15;
        step(0,0,0,0);
        restore = 1'b0;
        check("restore_sat_cnt", {28'b0, ckpt_cnt}, 32'd8);
        step(0,0,1,0);
`endif

        step(0,0,1,0);
        q.delete();
        for (int n = 0; n < 3000; n++) begin
            logic pu, po, fl;
            logic [31:0] a;
            pu = ($urandom_range(0, 99) < 45);
            po = ($urandom_range(0, 99) < 40);
            fl = ($urandom_range(0, 99) < 3);
            a  = $urandom;
            step(pu, po, fl, a);
            model(pu, po, fl, a);
            check("rnd_valid", {31'b0, valid}, {31'b0, q.size() != 0});
            if (q.size() != 0) check("rnd_top", top, q[q.size()-1]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
